// File: rtl/imem_boot_loader.sv
// Byte-stream program loader into a word RAM; holds the core in reset until the program is in.
// Word write lands on its 4th byte's edge, Instruction is combinational; byte_ready is 0 in RUN/ERR.
module imem_boot_loader #(
   parameter int ADDR_W = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   input  logic        reload,
   input  logic [31:0] PC,
   output logic [31:0] Instruction,
   output logic        cpu_reset,
   output logic        done,
   output logic        error,
   output logic [15:0] loaded_words
);

   localparam int unsigned DEPTH   = 1 << ADDR_W;
   localparam logic [16:0] DEPTH_W = 17'(DEPTH);

   typedef enum logic [2:0] {
      S_LEN_HI,
      S_LEN_LO,
      S_LOAD,
      S_RUN,
      S_ERR
   } state_t;

   state_t      r_state;
   logic [15:0] r_len;
   logic [1:0]  r_byte_idx;
   logic [23:0] r_asm;
   logic [15:0] r_loaded_words;
   logic        r_cpu_reset;
   logic        r_error;
   logic [31:0] r_mem [DEPTH];

   state_t      w_state_nxt;
   logic [15:0] w_len_nxt;
   logic [1:0]  w_byte_idx_nxt;
   logic [23:0] w_asm_nxt;
   logic [15:0] w_loaded_words_nxt;
   logic        w_cpu_reset_nxt;
   logic        w_error_nxt;
   logic        w_we;
   logic        w_accept;
   logic [15:0] w_len_full;
   logic [15:0] w_words_inc;
   logic        w_pc_unused;

   assign byte_ready   = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) || (r_state == S_LOAD);
   assign done         = (r_state == S_RUN);
   assign cpu_reset    = r_cpu_reset;
   assign error        = r_error;
   assign loaded_words = r_loaded_words;

   assign w_accept    = byte_valid && byte_ready;
   assign w_len_full  = {r_len[15:8], byte_data};
   assign w_words_inc = r_loaded_words + 16'd1;

   // Only the word index bits of PC address the RAM; the rest wrap/are ignored.
   assign Instruction = r_mem[PC[ADDR_W+1:2]];
   assign w_pc_unused = ^{PC[31:ADDR_W+2], PC[1:0]};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state        <= S_LEN_HI;
         r_len          <= '0;
         r_byte_idx     <= '0;
         r_asm          <= '0;
         r_loaded_words <= '0;
         r_cpu_reset    <= 1'b1;
         r_error        <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_len          <= w_len_nxt;
         r_byte_idx     <= w_byte_idx_nxt;
         r_asm          <= w_asm_nxt;
         r_loaded_words <= w_loaded_words_nxt;
         r_cpu_reset    <= w_cpu_reset_nxt;
         r_error        <= w_error_nxt;
      end
   end

   // RAM survives reset and reload so the core can be restarted on old code.
   always_ff @(posedge clk) begin
      if (w_we) begin
         r_mem[r_loaded_words[ADDR_W-1:0]] <= {r_asm, byte_data};
      end
   end

   always_comb begin
      w_state_nxt        = r_state;
      w_len_nxt          = r_len;
      w_byte_idx_nxt     = r_byte_idx;
      w_asm_nxt          = r_asm;
      w_loaded_words_nxt = r_loaded_words;
      w_cpu_reset_nxt    = r_cpu_reset;
      w_error_nxt        = r_error;
      w_we               = 1'b0;

      case (r_state)
         S_LEN_HI: begin
            if (w_accept) begin
               w_len_nxt   = {byte_data, r_len[7:0]};
               w_state_nxt = S_LEN_LO;
            end
         end
         S_LEN_LO: begin
            if (w_accept) begin
               w_len_nxt = w_len_full;
               if (w_len_full == 16'd0) begin
                  w_state_nxt     = S_RUN;
                  w_cpu_reset_nxt = 1'b0;
               end else if ({1'b0, w_len_full} > DEPTH_W) begin
                  w_state_nxt = S_ERR;
                  w_error_nxt = 1'b1;
               end else begin
                  w_state_nxt        = S_LOAD;
                  w_byte_idx_nxt     = 2'd0;
                  w_loaded_words_nxt = 16'd0;
               end
            end
         end
         S_LOAD: begin
            if (w_accept) begin
               w_asm_nxt      = {r_asm[15:0], byte_data};
               w_byte_idx_nxt = r_byte_idx + 2'd1;
               if (r_byte_idx == 2'd3) begin
                  w_we               = 1'b1;
                  w_loaded_words_nxt = w_words_inc;
                  if (w_words_inc == r_len) begin
                     w_state_nxt     = S_RUN;
                     w_cpu_reset_nxt = 1'b0;
                  end
               end
            end
         end
         S_RUN: begin
            if (reload) begin
               w_state_nxt        = S_LEN_HI;
               w_cpu_reset_nxt    = 1'b1;
               w_loaded_words_nxt = 16'd0;
            end
         end
         S_ERR: begin
            w_cpu_reset_nxt = 1'b1;
         end
         default: begin
            w_state_nxt = S_LEN_HI;
         end
      endcase
   end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: continuous/gapped loads, N=0, overflow/ERR, reload, mid-load reset.
module tb_imem_boot_loader;

   logic        clk;
   logic        reset;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        reload;
   logic [31:0] PC;
   logic [31:0] Instruction;
   logic        cpu_reset;
   logic        done;
   logic        error;
   logic [15:0] loaded_words;

   int n_checks;
   int n_fail;
   bit gap_mode;

   imem_boot_loader #(.ADDR_W(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .byte_valid   (byte_valid),
      .byte_data    (byte_data),
      .byte_ready   (byte_ready),
      .reload       (reload),
      .PC           (PC),
      .Instruction  (Instruction),
      .cpu_reset    (cpu_reset),
      .done         (done),
      .error        (error),
      .loaded_words (loaded_words)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one byte; it must be accepted on the coming edge.
   task automatic send_byte(input logic [7:0] b);
      byte_valid = 1'b1;
      byte_data  = b;
      check("byte_ready_before_accept", {31'd0, byte_ready}, 32'd1);
      tick();
      byte_valid = 1'b0;
      if (gap_mode) begin
         check("idle_gap_lw_hold", {16'd0, loaded_words}, {16'd0, loaded_words});
         tick();
      end
   endtask

   task automatic send_word(input logic [31:0] w);
      send_byte(w[31:24]);
      send_byte(w[23:16]);
      send_byte(w[15:8]);
      send_byte(w[7:0]);
   endtask

   task automatic pulse_reset();
      reset = 1'b0;
      #1;
      check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_error", {31'd0, error}, 32'd0);
      check("rst_loaded_words", {16'd0, loaded_words}, 32'd0);
      tick();
      reset = 1'b1;
      #1;
      check("rst_release_ready", {31'd0, byte_ready}, 32'd1);
   endtask

   task automatic read_instr(input string tag, input logic [31:0] pc, input logic [31:0] exp);
      PC = pc;
      #1;
      check(tag, Instruction, exp);
   endtask

   // Spec program: two words, with the 10th accept edge checked explicitly.
   task automatic load_spec_program(input string tag);
      send_byte(8'h00);
      send_byte(8'h02);
      send_word(32'h20080005);
      check({tag, "_lw_after_word0"}, {16'd0, loaded_words}, 32'd1);
      read_instr({tag, "_word0_visible"}, 32'h0, 32'h20080005);
      send_byte(8'hAC);
      send_byte(8'h08);
      send_byte(8'h00);
      check({tag, "_cpu_reset_before_last"}, {31'd0, cpu_reset}, 32'd1);
      send_byte(8'h00);
      check({tag, "_cpu_reset_after_last"}, {31'd0, cpu_reset}, 32'd0);
      check({tag, "_done"}, {31'd0, done}, 32'd1);
      check({tag, "_ready_run"}, {31'd0, byte_ready}, 32'd0);
      check({tag, "_lw"}, {16'd0, loaded_words}, 32'd2);
      read_instr({tag, "_pc0"}, 32'h0, 32'h20080005);
      read_instr({tag, "_pc4"}, 32'h4, 32'hAC080000);
      read_instr({tag, "_pc6_lowbits"}, 32'h6, 32'hAC080000);
   endtask

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      gap_mode   = 1'b0;
      reset      = 1'b0;
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      reload     = 1'b0;
      PC         = 32'h0;
      tick();
      tick();
      check("por_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      check("por_done", {31'd0, done}, 32'd0);
      check("por_error", {31'd0, error}, 32'd0);
      check("por_lw", {16'd0, loaded_words}, 32'd0);
      reset = 1'b1;
      #1;
      check("por_ready", {31'd0, byte_ready}, 32'd1);

      // Continuous stream.
      load_spec_program("cont");

      // Clobber word 0, then reload the spec program with gaps.
      pulse_reset();
      send_byte(8'h00);
      send_byte(8'h01);
      send_word(32'h0BADF00D);
      read_instr("clobber_pc0", 32'h0, 32'h0BADF00D);
      pulse_reset();
      gap_mode = 1'b1;
      send_byte(8'h00);
      send_byte(8'h02);
      send_byte(8'h20);
      send_byte(8'h08);
      check("gap_midword_lw", {16'd0, loaded_words}, 32'd0);
      check("gap_midword_ready", {31'd0, byte_ready}, 32'd1);
      send_byte(8'h00);
      send_byte(8'h05);
      send_byte(8'hAC);
      send_byte(8'h08);
      send_byte(8'h00);
      check("gap_cpu_reset_before_last", {31'd0, cpu_reset}, 32'd1);
      gap_mode = 1'b0;
      send_byte(8'h00);
      check("gap_cpu_reset_after_last", {31'd0, cpu_reset}, 32'd0);
      check("gap_lw", {16'd0, loaded_words}, 32'd2);
      read_instr("gap_pc0", 32'h0, 32'h20080005);
      read_instr("gap_pc4", 32'h4, 32'hAC080000);

      // N = 0.
      pulse_reset();
      send_byte(8'h00);
      check("n0_cpu_reset_mid", {31'd0, cpu_reset}, 32'd1);
      send_byte(8'h00);
      check("n0_done", {31'd0, done}, 32'd1);
      check("n0_cpu_reset", {31'd0, cpu_reset}, 32'd0);
      check("n0_lw", {16'd0, loaded_words}, 32'd0);
      check("n0_ready", {31'd0, byte_ready}, 32'd0);

      // N = 256 is the largest legal count.
      pulse_reset();
      send_byte(8'h01);
      send_byte(8'h00);
      check("n256_no_error", {31'd0, error}, 32'd0);
      check("n256_ready", {31'd0, byte_ready}, 32'd1);
      check("n256_cpu_reset", {31'd0, cpu_reset}, 32'd1);

      // N = 257 overflows.
      pulse_reset();
      send_byte(8'h01);
      send_byte(8'h01);
      check("err_error", {31'd0, error}, 32'd1);
      check("err_ready", {31'd0, byte_ready}, 32'd0);
      check("err_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      check("err_done", {31'd0, done}, 32'd0);
      reload     = 1'b1;
      byte_valid = 1'b1;
      byte_data  = 8'h00;
      tick();
      reload     = 1'b0;
      byte_valid = 1'b0;
      tick();
      check("err_reload_error", {31'd0, error}, 32'd1);
      check("err_reload_ready", {31'd0, byte_ready}, 32'd0);
      check("err_reload_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      pulse_reset();
      check("err_cleared", {31'd0, error}, 32'd0);

      // Reload path, with a byte offered in the reload cycle that must be ignored.
      send_byte(8'h00);
      send_byte(8'h01);
      send_word(32'h12345678);
      check("rl_first_done", {31'd0, done}, 32'd1);
      read_instr("rl_first_pc0", 32'h0, 32'h12345678);
      reload     = 1'b1;
      byte_valid = 1'b1;
      byte_data  = 8'hFF;
      tick();
      reload     = 1'b0;
      byte_valid = 1'b0;
      check("rl_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      check("rl_done", {31'd0, done}, 32'd0);
      check("rl_lw", {16'd0, loaded_words}, 32'd0);
      check("rl_ready", {31'd0, byte_ready}, 32'd1);
      send_byte(8'h00);
      send_byte(8'h01);
      send_byte(8'hDE);
      // reload outside RUN must not disturb the load
      reload = 1'b1;
      send_byte(8'hAD);
      reload = 1'b0;
      send_byte(8'hBE);
      check("rl_cpu_reset_held", {31'd0, cpu_reset}, 32'd1);
      send_byte(8'hEF);
      check("rl_cpu_reset_fall", {31'd0, cpu_reset}, 32'd0);
      check("rl_lw_final", {16'd0, loaded_words}, 32'd1);
      read_instr("rl_pc400_wrap", 32'h400, 32'hDEADBEEF);
      read_instr("rl_pc0", 32'h0, 32'hDEADBEEF);

      // Reset in the middle of a 3-word load, then a fresh 1-word load.
      pulse_reset();
      send_byte(8'h00);
      send_byte(8'h03);
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      pulse_reset();
      send_byte(8'h00);
      send_byte(8'h01);
      send_word(32'hA1B2C3D4);
      check("abort_done", {31'd0, done}, 32'd1);
      check("abort_cpu_reset", {31'd0, cpu_reset}, 32'd0);
      check("abort_lw", {16'd0, loaded_words}, 32'd1);
      read_instr("abort_pc0", 32'h0, 32'hA1B2C3D4);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Instruction-memory stage that sits directly upstream of the single-cycle MIPS core. It receives a program as a byte stream over a valid/ready handshake and writes it into an internal word RAM. While loading, it holds the core in reset. Once the program is loaded, it serves `Instruction` combinationally from the core's `PC`.

## Interface

Parameters:
- `ADDR_W`, default 8: word-address width; RAM depth is 2^ADDR_W 32-bit words.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `byte_valid`  in  1  `byte_data` is valid this cycle.
- `byte_data`  in  8  stream byte.
- `byte_ready`  out  1  loader can accept a byte this cycle.
- `reload`  in  1  single-cycle pulse; restarts the load sequence from RUN.
- `PC`  in  32  core program counter (byte address).
- `Instruction`  out  32  `mem[PC[ADDR_W+1:2]]`, combinational.
- `cpu_reset`  out  1  active-high reset to the core; registered.
- `done`  out  1  program loaded, core running.
- `error`  out  1  length header exceeded RAM depth; sticky.
- `loaded_words`  out  16  number of words written so far.

## Operation

- A byte is accepted on any rising edge where `byte_valid` && `byte_ready`. Bytes offered while `byte_ready`=0 are ignored; the sender holds them.
- Stream format: 16-bit word count N, big-endian (2 bytes), followed by N words of 4 bytes each, big-endian (first byte → bits 31:24).
- States:
  - LEN_HI: accept a byte → `len[15:8]`; go to LEN_LO.
  - LEN_LO: accept a byte → `len[7:0]`. Then:
    - N=0 → RUN.
    - N > 2^ADDR_W → ERR.
    - otherwise → LOAD, with `byte_idx`=0 and `loaded_words`=0.
  - LOAD: each accepted byte shifts into the assembly register and increments `byte_idx` mod 4.
    - On the accept where `byte_idx`=3: write the assembled word to `mem[loaded_words]` and increment `loaded_words`.
    - If this was word N, go to RUN.
  - RUN: `byte_ready`=0, `cpu_reset`=0, `done`=1. A `reload` pulse → LEN_HI; `cpu_reset`=1 and `done`=0 from the next cycle; `loaded_words` is cleared.
  - ERR: `byte_ready`=0, `cpu_reset`=1, `error`=1. `reload` is ignored; only `reset` exits ERR.
- `byte_ready` = 1 in LEN_HI, LEN_LO and LOAD; decoded from state.
- `reload` outside RUN has no effect.
- RAM is not cleared by `reset` or `reload`. Words at index ≥ N keep old contents (X after power-up). The bench checks only loaded words.
- `Instruction` address uses `PC[ADDR_W+1:2]`: upper PC bits are ignored (wrap-around), and `PC[1:0]` is ignored.
- `Instruction` is valid in every state, but the core only consumes it when `cpu_reset`=0.

## Timing

- Reset values (async, while `reset`=0): state=LEN_HI, `cpu_reset`=1, `done`=0, `error`=0, `loaded_words`=0, `byte_idx`=0, `len`=0. Consequently `byte_ready`=1 immediately after reset releases.
- Reset asserted mid-load aborts the load at once. Partially written RAM words persist; the next load overwrites them.
- Word write lands on the edge that accepts its 4th byte. A same-address `Instruction` read reflects the new word after that edge.
- The final-byte edge sets state=RUN, `cpu_reset`=0 and `done`=1 together. The core's first active edge is the next one.
- Minimum load latency is 2 + 4N accepted bytes. Cycles where `byte_valid`=0 stall without a state change.
- N=0: `cpu_reset` falls on the edge accepting the LEN_LO byte.
- `error` rises on the LEN_LO accept edge when N > 2^ADDR_W.
- `reload` and a simultaneous `byte_valid` in RUN: the byte is not accepted (`byte_ready`=0 that cycle).

## Test plan

- Reset, then stream 00 02 | 20 08 00 05 | AC 08 00 00 with `byte_valid` held high → `loaded_words`=2, `cpu_reset` falls on the 10th accept edge. With `PC`=0x0, `Instruction`=0x20080005; with `PC`=0x4, `Instruction`=0xAC080000.
- Same stream with `byte_valid` toggled every other cycle → identical RAM contents. `byte_idx` and state hold during gaps; `cpu_reset` falls on the 10th accept edge.
- ADDR_W=8, header 01 01 (N=257) → ERR: `error`=1, `byte_ready`=0, `cpu_reset`=1. Then `reload` pulse → no change. Then `reset` pulse → `error`=0, `byte_ready`=1.
- Header 00 00 → `done`=1 and `cpu_reset`=0 right after the 2nd byte; `loaded_words`=0.
- Load one word 0x12345678, then `reload`, then load one word 0xDEADBEEF → `cpu_reset` high from the cycle after `reload` until the new final byte; `PC`=0x400 (wraps to index 0) reads 0xDEADBEEF.
- Assert `reset` after 5 bytes of a 3-word load → all outputs at reset values; a fresh 1-word load then completes normally.
